serial_ck_rx: RTL
=================

Name: serial_ck_rx

Overview:
Receiver and measurer for the phased serial clock burst produced by the team's serial clock transmitter.
- The burst format is: idle at y0; then ncyc cycles, each a !y0 half of n1 ticks followed by a y0 half of n2 ticks; then back to idle.
- The block synchronises the incoming line, counts cycles, and measures the first-cycle half periods in clk cycles.
- It ends the burst on an idle timeout and presents the result through a valid/ack handshake to the control logic.

Parameters:
P_SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).
P_CNT_W, 32, width of the duration counters and measurement outputs.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ck_in  input  1  serial clock line, asynchronous to clk
y0  input  1  idle line level; sampled at burst start
timeout  input  32  clk cycles at level y0 that end a burst; 0 is treated as 1
valid  output  1  result available; held until acknowledged
ack  input  1  consumer accepts the result
ncyc  output  8  number of cycles in the burst (saturates at 255)
n1  output  P_CNT_W  clk cycles of the first !y0 half
n2  output  P_CNT_W  clk cycles of the first y0 half between cycles; 0 if ncyc==1
err  output  1  burst error (stuck-active line or cycle overflow)

Behaviour:
- Reset (rst_n low, asynchronous): valid=0, ncyc=0, n1=0, n2=0, err=0.
  - Synchronizer flops load y0 (line treated as idle). FSM goes to IDLE. All counters are cleared.
- Synchronizer: ck_in passes through P_SYNC_STAGES flops to give line_s, with latency P_SYNC_STAGES clocks. prev_s holds line_s from the previous clock.
- Edge: rise_act = (line_s != y0_l) && (prev_s == y0_l). fall_act is the reverse. y0_l is y0 latched at burst start; in IDLE, y0_l tracks y0.
- Duration counter dur: clears on each state entry, increments once per clk, saturates at all-ones.
- FSM:
  - IDLE: on rise_act, go to ACT. Latch y0_l, set cyc=1, clear err_i and the first-cycle flags.
    - A line sitting at !y0 with no edge, including after reset or after ack, never starts a burst.
  - ACT (line at !y0):
    - On fall_act, go to INACT. If this is the first cycle, n1_i = dur+1.
    - If dur+1 == timeout_eff, set err_i and go to DONE.
  - INACT (line at y0):
    - On rise_act, go to ACT. If this is the first gap, n2_i = dur+1. cyc increments; if cyc==255 already, it stays at 255 and err_i is set.
    - If dur+1 == timeout_eff, go to DONE.
  - DONE: valid=1, and outputs are driven from the latched values (n2 stays 0 if no second cycle occurred). Line activity is ignored.
    - On ack with valid high, valid drops the next clock, state goes to IDLE, and outputs hold their last values.
- Durations are measured in clk cycles from the synchronized edge to the next synchronized edge. The expected value is the transmitter half length times the transmitter tick period, ±1.
- ack while valid=0 is ignored. Simultaneous edge and timeout in the same cycle: the edge wins.
- Reset mid-burst aborts the burst and produces no valid.
- Latency: valid rises timeout_eff + P_SYNC_STAGES + 1 clocks after the final y0 transition of the line.

Optional Feature:
SERIAL_CK_RX_GLITCH_EN
- Defined: adds input min_half[15:0]. In ACT or INACT, an opposite-level edge seen when dur+1 < min_half is treated as a glitch: no state change, no measurement, err_i is set, and the burst continues.
- Undefined: no min_half port; every synchronized edge is honoured.

Test Plan:
- y0=0, transmitter burst ncyc=4, n1=3, n2=5 (1 tick = 1 clk), timeout=20 -> valid with ncyc=4, n1=3, n2=5, err=0; ack clears valid the next clock.
- y0=1, single-cycle burst n1=7, timeout=10 -> ncyc=1, n1=7, n2=0, err=0; line idles at 1 throughout.
- Line driven to !y0 and held 50 clocks, timeout=16 -> valid with err=1, ncyc=1, n1=16.
- Burst of 300 cycles, n1=n2=2 -> ncyc=255, err=1.
- Hold ack low for 100 clocks after valid and run a second burst meanwhile -> the first result stays stable and the second burst is ignored. After ack, a third burst of ncyc=2 is captured correctly.
- Assert rst_n low mid-burst (cycle 2 of 4) -> all outputs are 0 immediately. Line held at !y0 through release -> no burst starts until the next y0→!y0 edge.

Source files
------------

// File: rtl/serial_ck_rx_if.sv
// Result handshake of serial_ck_rx: the receiver presents a measured burst, the consumer acks it.
`timescale 1ns/1ps
interface serial_ck_rx_if #(
   parameter int unsigned P_CNT_W = 32
);
   logic               valid;
   logic               ack;
   logic [7:0]         ncyc;
   logic [P_CNT_W-1:0] n1;
   logic [P_CNT_W-1:0] n2;
   logic               err;

   modport master (output valid, ncyc, n1, n2, err, input ack);
   modport slave  (input valid, ncyc, n1, n2, err, output ack);
endinterface

// File: rtl/serial_ck_rx.sv
// serial_ck_rx: synchronises a phased serial clock burst, counts its cycles and measures the
// first-cycle half periods. Define SERIAL_CK_RX_GLITCH_EN to add the min_half glitch filter.
`timescale 1ns/1ps
module serial_ck_rx #(
   parameter int unsigned P_SYNC_STAGES = 2,
   parameter int unsigned P_CNT_W       = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ck_in,
   input  logic        y0,
   input  logic [31:0] timeout,
`ifdef SERIAL_CK_RX_GLITCH_EN
   input  logic [15:0] min_half,
`endif
   serial_ck_rx_if.master res
);

   localparam int unsigned CmpW = ((P_CNT_W > 32) ? P_CNT_W : 32) + 1;

   typedef enum logic [1:0] {StIdle, StAct, StInact, StDone} state_e;

   state_e                   state_q, state_d;
   logic [P_SYNC_STAGES-1:0] sync_q;
   logic                     prev_q;
   logic [P_SYNC_STAGES:0]   settle_q;
   logic [P_CNT_W-1:0]       dur_q, dur_d, meas;
   logic [7:0]               cyc_q, cyc_d;
   logic [P_CNT_W-1:0]       n1_q, n1_d, n2_q, n2_d;
   logic                     erri_q, erri_d;
   logic                     y0_q, y0_d;
   logic [7:0]               ncyc_q;
   logic [P_CNT_W-1:0]       n1o_q, n2o_q;
   logic                     erro_q;
   logic                     line_s, settled, y0_l, rise_act, fall_act;
   logic                     tmo_hit, short_half, load_out, valid;
   logic [31:0]              timeout_eff;
   logic [CmpW-1:0]          dur_p1;

   // Flops preload the idle level so reset itself never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= {P_SYNC_STAGES{y0}};
         prev_q   <= y0;
         settle_q <= '0;
      end else begin
         sync_q   <= {sync_q[P_SYNC_STAGES-2:0], ck_in};
         prev_q   <= sync_q[P_SYNC_STAGES-1];
         settle_q <= {settle_q[P_SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign line_s  = sync_q[P_SYNC_STAGES-1];
   // Edges are ignored until both line_s and prev_q reflect the real line after reset.
   assign settled = settle_q[P_SYNC_STAGES];
   assign y0_l    = (state_q == StIdle) ? y0 : y0_q;

   assign rise_act    = settled && (line_s != y0_l) && (prev_q == y0_l);
   assign fall_act    = settled && (line_s == y0_l) && (prev_q != y0_l);
   assign timeout_eff = (timeout == 32'd0) ? 32'd1 : timeout;
   assign dur_p1      = CmpW'(dur_q) + CmpW'(1);
   assign tmo_hit     = (dur_p1 == CmpW'(timeout_eff));
   assign meas        = (&dur_q) ? dur_q : dur_q + P_CNT_W'(1);

`ifdef SERIAL_CK_RX_GLITCH_EN
   assign short_half = (dur_p1 < CmpW'(min_half));
`else
   assign short_half = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      n1_d    = n1_q;
      n2_d    = n2_q;
      erri_d  = erri_q;
      y0_d    = y0_q;
      unique case (state_q)
         StIdle: begin
            if (rise_act) begin
               state_d = StAct;
               y0_d    = y0;
               cyc_d   = 8'd1;
               n1_d    = '0;
               n2_d    = '0;
               erri_d  = 1'b0;
            end
         end
         StAct: begin
            if (fall_act && short_half) begin
               erri_d = 1'b1;
            end
            if (fall_act && !short_half) begin
               state_d = StInact;
               if (cyc_q == 8'd1) n1_d = meas;
            end else if (tmo_hit) begin
               // Line stuck at the active level: close the burst as an error.
               state_d = StDone;
               erri_d  = 1'b1;
               if (cyc_q == 8'd1) n1_d = meas;
            end
         end
         StInact: begin
            if (rise_act && short_half) begin
               erri_d = 1'b1;
            end
            if (rise_act && !short_half) begin
               state_d = StAct;
               if (cyc_q == 8'd1) n2_d = meas;
               if (cyc_q == 8'd255) erri_d = 1'b1;
               else                 cyc_d  = cyc_q + 8'd1;
            end else if (tmo_hit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (res.ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      dur_d = (state_d != state_q) ? '0 : meas;
   end

   always_comb begin
      valid    = (state_q == StDone);
      load_out = (state_d == StDone) && (state_q != StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         dur_q   <= '0;
         cyc_q   <= '0;
         n1_q    <= '0;
         n2_q    <= '0;
         erri_q  <= 1'b0;
         y0_q    <= 1'b0;
         ncyc_q  <= '0;
         n1o_q   <= '0;
         n2o_q   <= '0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dur_q   <= dur_d;
         cyc_q   <= cyc_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         erri_q  <= erri_d;
         y0_q    <= y0_d;
         if (load_out) begin
            ncyc_q <= cyc_d;
            n1o_q  <= n1_d;
            n2o_q  <= n2_d;
            erro_q <= erri_d;
         end
      end
   end

   assign res.valid = valid;
   assign res.ncyc  = ncyc_q;
   assign res.n1    = n1o_q;
   assign res.n2    = n2o_q;
   assign res.err   = erro_q;

endmodule
